neu_relax: RTL

- Parametrised second-generation node execution unit for the grid shortest-path engine. One instance per grid cell.
- Holds the cell's traversal weight, its best-known path cost and its back-pointer direction.
- Relaxes against 4 or 8 neighbour costs each cycle, using saturating arithmetic.
- Adds a start/halt FSM and local convergence detection, which the array controller ANDs across cells to end a search.

---
 rtl/neu_relax.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/neu_relax.sv
// Grid shortest-path node: weight, best cost, back-pointer, settle FSM.
// Optional NEU_UPD_STATS_EN adds the upd_cnt update counter output.
module neu_relax #(
  parameter int COST_W        = 16,
  parameter int WGT_W         = 4,
  parameter int PERP_STEP     = 2,
  parameter int DIAG_STEP     = 3,
  parameter int CONN8         = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                ld,
  input  logic [WGT_W-1:0]    ld_weight,
  input  logic                start,
  input  logic                halt,
  input  logic [8*COST_W-1:0] adj_cost,
  input  logic [7:0]          adj_vld,
`ifdef NEU_UPD_STATS_EN
  output logic [7:0]          upd_cnt,
`endif
  output logic [COST_W-1:0]   path_cost,
  output logic [2:0]          path_dir,
  output logic                path_mod,
  output logic                settled,
  output logic                busy
);

  localparam int XW = COST_W + 2;
  localparam logic [COST_W-1:0] INF = '1;
  localparam logic [WGT_W-1:0] BLK = '1;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELAX   = 2'd1,
    SETTLED = 2'd2
  } state_t;

  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [WGT_W-1:0] weight;
  logic [COST_W-1:0] cand [8];
  logic [7:0] elig;
  logic [COST_W-1:0] best;
  logic [2:0] best_k;
  logic found;
  logic active;
  logic relax_en;
  logic upd;

  for (genvar k = 0; k < 8; k++) begin : g_cand
    logic [COST_W-1:0] a;
    logic [XW-1:0] sum;
    assign a = adj_cost[k*COST_W +: COST_W];
    assign sum = XW'(a)
               + (XW'(weight) << 1)
               + XW'((k % 2) != 0 ? DIAG_STEP
                                  : PERP_STEP);
    assign cand[k] = (a == INF || sum >= XW'(INF))
                   ? INF : sum[COST_W-1:0];
    assign elig[k] = adj_vld[k]
                   && (CONN8 != 0 || (k % 2) == 0)
                   && cand[k] < path_cost;
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best   = INF;
    best_k = 3'd0;
    found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (elig[k] && (!found || cand[k] < best)) begin
        best   = cand[k];
        best_k = 3'(k);
        found  = 1'b1;
      end
    end
  end

  assign active = state != IDLE;
  assign relax_en = active && !clr && !ld && !halt;
  assign upd = relax_en && found && weight != BLK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clr) begin
      cnt_n = '0;
    end else if (ld) begin
      if (active) begin
        state_n = RELAX;
        cnt_n   = '0;
      end
    end else if (halt) begin
      state_n = IDLE;
    end else if (!active) begin
      if (start) begin
        state_n = RELAX;
        cnt_n   = '0;
      end
    end else if (upd) begin
      state_n = RELAX;
      cnt_n   = '0;
    end else if (state == RELAX) begin
      if (cnt >= LAST) state_n = SETTLED;
      else cnt_n = cnt + 8'd1;
    end
  end

  always_comb begin
    busy    = active;
    settled = state == SETTLED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      path_cost <= INF;
      path_dir  <= 3'd0;
      path_mod  <= 1'b0;
      weight    <= '0;
    end else begin
      path_mod <= upd;
      if (clr) begin
        path_cost <= '0;
        path_dir  <= 3'd0;
      end else if (ld) begin
        weight <= ld_weight;
        if (ld_weight == BLK) begin
          path_cost <= INF;
          path_dir  <= 3'd0;
        end
      end else if (upd) begin
        path_cost <= best;
        path_dir  <= best_k;
      end
    end
  end

`ifdef NEU_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clr) upd_cnt <= '0;
    else if (upd && upd_cnt != 8'hFF)
      upd_cnt <= upd_cnt + 8'd1;
  end
`endif

endmodule
